// File: rtl/hog_svm_pkg.sv
// rtl/hog_svm_pkg.sv - shared types and helpers for the HOG/SVM score collector
package hog_svm_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // ceil(log2(n)), never less than 1 so single-lane builds still get a 1-bit lane field
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

  // FIFO entry layout, MSB to LSB: {result, sw_id, lane, is_person}
  function automatic int entry_width(input int res_w, input int sw_w, input int ch_w);
    return res_w + sw_w + ch_w + 1;
  endfunction

endpackage

// File: rtl/hog_svm_fifo.sv
// rtl/hog_svm_fifo.sv - synchronous FIFO with full/empty, legal push+pop at full or empty
module hog_svm_fifo
  import hog_svm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // head reads as zero while empty so the data outputs are clean after reset
  assign rdata   = empty ? '0 : mem_q[rd_q[AW-1:0]];

  // pointer advance
  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
  end

  // pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // storage write, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/hog_svm_collect.sv
// rtl/hog_svm_collect.sv - collects per-lane SVM scores into one FIFO stream; HOG_SVM_COLLECT_STATS_EN adds det_cnt/drop_cnt
module hog_svm_collect
  import hog_svm_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int FEA_I = 4,
  parameter  int FEA_F = 28,
  parameter  int SW_W  = 11,
  parameter  int DEPTH = 16,
  localparam int RES_W = FEA_I + FEA_F,
  localparam int CH_W  = clog2_min1(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        i_valid,
  input  logic [NCH*RES_W-1:0]  i_result,
  input  logic [NCH*SW_W-1:0]   i_sw_id,
  input  logic                  i_frame_end,
  input  logic                  mode,
  input  logic [RES_W-1:0]      threshold,
  input  logic                  o_ready,
  output logic                  o_valid,
  output logic [RES_W-1:0]      o_result,
  output logic [SW_W-1:0]       o_sw_id,
  output logic [CH_W-1:0]       o_ch,
  output logic                  o_is_person,
  output logic                  o_frame_done,
  output logic                  overflow
`ifdef HOG_SVM_COLLECT_STATS_EN
  ,
  output logic [15:0]           det_cnt,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int ENT_W = entry_width(RES_W, SW_W, CH_W);

  logic [NCH-1:0]   held_q, held_d;
  logic [RES_W-1:0] res_q [NCH];
  logic [RES_W-1:0] res_d [NCH];
  logic [SW_W-1:0]  sw_q  [NCH];
  logic [SW_W-1:0]  sw_d  [NCH];
  logic [CH_W-1:0]  rr_q, rr_d;
  logic             overflow_q, overflow_d;
  logic [NCH-1:0]   drop;
  state_e           state_q, state_d;

  logic             fifo_full, fifo_empty, push, pop;
  logic             grant_v, g_person;
  logic [CH_W-1:0]  grant_idx;
  logic [ENT_W-1:0] wdata, rdata;

  assign pop      = o_valid && o_ready;
  assign g_person = $signed(res_q[grant_idx]) > $signed(threshold);
  assign push     = grant_v && (!mode || g_person);
  assign wdata    = {res_q[grant_idx], sw_q[grant_idx], grant_idx, g_person};
  assign o_valid  = !fifo_empty;
  assign overflow = overflow_q;
  assign {o_result, o_sw_id, o_ch, o_is_person} = rdata;

  // round-robin pick of one held lane, searching from the lane after the last grant
  always_comb begin
    grant_v   = 1'b0;
    grant_idx = rr_q;
    for (int k = 1; k <= NCH; k++) begin
      if (!grant_v && held_q[(int'(rr_q) + k) % NCH]) begin
        grant_v   = 1'b1;
        grant_idx = CH_W'((int'(rr_q) + k) % NCH);
      end
    end
    // a full FIFO only takes a grant when the head leaves in the same cycle
    if (fifo_full && !pop) grant_v = 1'b0;
  end

  // lane holding registers: free on grant, capture new strobe, drop on collision
  always_comb begin
    held_d = held_q;
    res_d  = res_q;
    sw_d   = sw_q;
    drop   = '0;
    rr_d   = grant_v ? grant_idx : rr_q;
    for (int n = 0; n < NCH; n++) begin
      if (grant_v && (grant_idx == CH_W'(n))) held_d[n] = 1'b0;
      if (i_valid[n]) begin
        if (held_d[n]) begin
          drop[n] = 1'b1;
        end else begin
          held_d[n] = 1'b1;
          res_d[n]  = i_result[n*RES_W +: RES_W];
          sw_d[n]   = i_sw_id[n*SW_W +: SW_W];
        end
      end
    end
    overflow_d = overflow_q | (|drop);
  end

  // frame FSM next state and done pulse
  always_comb begin
    state_d      = state_q;
    o_frame_done = 1'b0;
    unique case (state_q)
      ST_RUN:   if (i_frame_end) state_d = ST_DRAIN;
      ST_DRAIN: if ((held_q == '0) && fifo_empty) state_d = ST_DONE;
      ST_DONE: begin
        o_frame_done = 1'b1;
        state_d      = ST_RUN;
      end
      default:  state_d = ST_RUN;
    endcase
  end

  // control state; rr starts at the last lane so lane 0 is first after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q     <= '0;
      rr_q       <= CH_W'(NCH - 1);
      overflow_q <= 1'b0;
      state_q    <= ST_RUN;
    end else begin
      held_q     <= held_d;
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  // lane payloads are qualified by held_q, so they carry no reset
  always_ff @(posedge clk) begin
    res_q <= res_d;
    sw_q  <= sw_d;
  end

  hog_svm_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef HOG_SVM_COLLECT_STATS_EN
  logic [15:0] det_q, det_d, drop_q, drop_d;
  logic [16:0] drop_sum;
  logic [3:0]  drop_n;

  // saturating counters; a detection in the done cycle starts the next frame's count
  always_comb begin
    drop_n = '0;
    for (int n = 0; n < NCH; n++) drop_n = drop_n + {3'b000, drop[n]};
    drop_sum = {1'b0, drop_q} + {13'd0, drop_n};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    if (o_frame_done)                                det_d = {15'd0, push && g_person};
    else if (push && g_person && det_q != 16'hFFFF) det_d = det_q + 16'd1;
    else                                             det_d = det_q;
  end

  // statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      det_q  <= '0;
      drop_q <= '0;
    end else begin
      det_q  <= det_d;
      drop_q <= drop_d;
    end
  end

  assign det_cnt  = det_q;
  assign drop_cnt = drop_q;
`endif

endmodule

// File: doc/hog_svm_collect.md
HOG_SVM_COLLECT -- requirements
Module: hog_svm_collect

Interface
REQ-001 SHALL have parameter NCH, default 4, number of hog/svm lanes collected (1..8).
REQ-002 SHALL have parameter FEA_I, default 4, integer bits of SVM score.
REQ-003 SHALL have parameter FEA_F, default 28, fraction bits of SVM score; RES_W = FEA_I+FEA_F.
REQ-004 SHALL have parameter SW_W, default 11, slide-window index width.
REQ-005 SHALL have parameter DEPTH, default 16, output FIFO entries (power of two, >=2).
REQ-006 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-008 SHALL have port i_valid, input, NCH, per-lane score strobe, no backpressure.
REQ-009 SHALL have port i_result, input, NCH*RES_W, per-lane signed score; lane n at [n*RES_W +: RES_W].
REQ-010 SHALL have port i_sw_id, input, NCH*SW_W, per-lane window index.
REQ-011 SHALL have port i_frame_end, input, 1, one-cycle pulse: no further lane strobes this frame.
REQ-012 SHALL have port mode, input, 1, 0 = forward all scores, 1 = forward detections only.
REQ-013 SHALL have port threshold, input, RES_W, signed detection threshold.
REQ-014 SHALL have port o_ready, input, 1, downstream accept.
REQ-015 SHALL have port o_valid, output, 1, FIFO head valid.
REQ-016 SHALL have port o_result, o_sw_id, o_ch, o_is_person, outputs, RES_W/SW_W/clog2(NCH) (min 1)/1, head entry fields.
REQ-017 SHALL have port o_frame_done, output, 1, one-cycle pulse when frame fully drained.
REQ-018 SHALL have port overflow, output, 1, sticky; a score was lost.

Function
REQ-019 SHALL capture each i_valid[n] into a one-entry lane holding register in the same cycle edge.
REQ-020 SHALL set overflow and drop the new score when i_valid[n] arrives while lane n is held and not granted that cycle; the held score is kept.
REQ-021 SHALL grant one held lane per cycle, round-robin starting after the last granted lane; lane 0 first after reset.
REQ-022 SHALL compute is_person = signed(result) > signed(threshold), strict.
REQ-023 SHALL, on grant, write {result, sw_id, lane, is_person} to the FIFO if mode=0 or is_person=1; otherwise discard; lane register freed either way.
REQ-024 SHALL not grant when FIFO is full unless a pop occurs the same cycle; a lane held while blocked is not overflow unless REQ-020 applies.
REQ-025 SHALL pop on o_valid & o_ready; simultaneous push and pop at full or empty SHALL be legal; minimum i_valid-to-o_valid latency 2 cycles.
REQ-026 SHALL hold o_* fields stable while o_valid=1 and o_ready=0.
REQ-027 SHALL run FSM RUN -> DRAIN on i_frame_end; DRAIN -> DONE when all lanes empty and FIFO empty; DONE pulses o_frame_done one cycle -> RUN.
REQ-028 SHALL ignore i_frame_end outside RUN; lane strobes in DRAIN SHALL be accepted normally.
REQ-029 SHALL sample mode and threshold at grant time.

Reset
REQ-030 SHALL, on rst, clear lane registers, FIFO pointers, RR pointer, overflow, enter RUN; o_valid=0, o_frame_done=0, o_* data 0.
REQ-031 SHALL let rst mid-frame discard all held/buffered scores with no o_frame_done.

Configuration
REQ-032 SHALL, with HOG_SVM_COLLECT_STATS_EN defined, add outputs det_cnt (16b, detections pushed this frame, cleared on o_frame_done, saturating) and drop_cnt (16b, saturating, cleared only by rst); without it, no such ports or logic.

Structure
REQ-033 SHALL put the FIFO entry struct width, state encoding, and clog2 helper in package hog_svm_pkg.
REQ-034 SHALL implement the FIFO as sub-module hog_svm_fifo (parametrised width/depth, full/empty).

Verification
REQ-035 SHALL test: NCH=4, all lanes strobe together, result 1.0/2.0/-1.0/0.5, threshold 0, mode=0 -> 4 outputs lanes 0,1,2,3, is_person 1,1,0,1.
REQ-036 SHALL test: mode=1 same stimulus -> 3 outputs lanes 0,1,3; lane 2 absent; overflow stays 0.
REQ-037 SHALL test: o_ready=0, 20 strobes on lane 0 spaced 2 cycles, DEPTH=16 -> 16 buffered, lane 0 held, later strobes overflow=1.
REQ-038 SHALL test: result equals threshold (0x10000000) -> is_person=0.
REQ-039 SHALL test: i_frame_end with 3 entries buffered, o_ready toggled -> o_frame_done exactly one cycle after last pop drains.
REQ-040 SHALL test: rst asserted with FIFO half full -> next cycle o_valid=0, overflow=0, no o_frame_done.
